// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and the rising-to-rising period of one
// external PWM input, counted in clk_i cycles. Each completed measurement is
// handed to a consumer through a single-entry valid/ready result register.
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a stability
// filter after the synchronizer. The filtered level follows the input only
// after the new value has been held for FiltCnt consecutive cycles.
//
// Ports:
//   clk_i         core clock
//   rst_i         synchronous active-high reset
//   enable_i      capture enable (level); low returns the FSM to IDLE
//   pwm_i         asynchronous PWM input
//   meas_valid_o  result register holds an unconsumed measurement
//   meas_ready_i  consumer accepts the result
//   high_o        high time of the measured cycle
//   period_o      rising-to-rising period
//   timeout_o     result was produced by counter saturation
//   overrun_o     sticky: a result was dropped while the register was full
//   clear_i       clears overrun_o (a simultaneous set wins)
//   level_o       synchronized (and filtered) input level
module pwm_capture #(
    parameter int CntDw   = 16,
    parameter int FiltCnt = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             pwm_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [CntDw-1:0] high_o,
    output logic [CntDw-1:0] period_o,
    output logic             timeout_o,
    output logic             overrun_o,
    input  logic             clear_i,
    output logic             level_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_e;

    localparam logic [CntDw-1:0] CNT_MAX = '1;
    localparam logic [CntDw-1:0] CNT_ONE = {{(CntDw-1){1'b0}}, 1'b1};

    if (FiltCnt < 2) begin : g_bad_filt
        $error("pwm_capture: FiltCnt must be >= 2");
    end

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronizer, optional filter, edge detector
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic lvl;
    logic prev_q;
    logic rise, fall;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FCW = $clog2(FiltCnt);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FiltCnt - 1);

    logic           filt_q;
    logic [FCW-1:0] fcnt_q;

    // fcnt_q counts consecutive samples that disagree with the filtered
    // level; the FiltCnt-th disagreeing sample commits the new level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FILT_LAST) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b0;
        else       prev_q <= lvl;
    end

    assign rise    = lvl & ~prev_q;
    assign fall    = ~lvl & prev_q;
    assign level_o = lvl;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CntDw-1:0] cnt_q, cnt_d;
    logic [CntDw-1:0] hi_q, hi_d;

    logic             res_v;
    logic [CntDw-1:0] res_high, res_period;
    logic             res_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        res_v       = 1'b0;
        res_high    = hi_q;
        res_period  = cnt_q;
        res_timeout = 1'b0;

        if (!enable_i) begin
            // Drop any partial measurement.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == CNT_MAX) begin
                        // Stuck high: report a timeout, wait for a fresh rise.
                        res_v       = 1'b1;
                        res_high    = CNT_MAX;
                        res_period  = CNT_MAX;
                        res_timeout = 1'b1;
                        state_d     = S_ARM;
                    end else if (fall) begin
                        state_d = S_LOW;
                        hi_d    = cnt_q;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (cnt_q == CNT_MAX) begin
                        res_v       = 1'b1;
                        res_high    = hi_q;
                        res_period  = CNT_MAX;
                        res_timeout = 1'b1;
                        state_d     = S_ARM;
                    end else if (rise) begin
                        // Closing rise also opens the next measurement.
                        res_v      = 1'b1;
                        res_high   = hi_q;
                        res_period = cnt_q;
                        state_d    = S_HIGH;
                        cnt_d      = CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-entry result register
    // ------------------------------------------------------------------
    logic load;
    assign load = res_v && (!meas_valid_o || meas_ready_i);

    // NOTE: the result registers are reset as well, because their contents
    // are visible on the outputs and must read 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meas_valid_o <= 1'b0;
            high_o       <= '0;
            period_o     <= '0;
            timeout_o    <= 1'b0;
        end else if (load) begin
            meas_valid_o <= 1'b1;
            high_o       <= res_high;
            period_o     <= res_period;
            timeout_o    <= res_timeout;
        end else if (meas_valid_o && meas_ready_i) begin
            meas_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                                    overrun_o <= 1'b0;
        else if (res_v && meas_valid_o && !meas_ready_i) overrun_o <= 1'b1;
        else if (clear_i)                             overrun_o <= 1'b0;
    end

endmodule
